mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares one single-port word-addressed memory between an instruction-fetch requester (I) and a load/store requester (D). Performs round-robin arbitration, byte-address to word-index translation and byte-lane/store-data formatting, and load extraction with sign/zero extension. Sits between the core's fetch/LSU stages and the memory; the memory takes registered ren/wen on posedge clk and returns dataout one edge later.

Parameters:
DEPTH, 1024, number of 32-bit words in the shared memory; word index >= DEPTH is out of range.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request, held until i_ack
i_addr  in  32  fetch byte address
i_ack  out  1  one-cycle completion pulse for I
i_rdata  out  32  fetched word, valid with i_ack
i_err  out  1  I error, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
d_unsigned  in  1  load zero-extend (1) / sign-extend (0)
d_addr  in  32  data byte address
d_wdata  in  32  store data, right-aligned
d_ack  out  1  one-cycle completion pulse for D
d_rdata  out  32  extended load data, valid with d_ack
d_err  out  1  D error, valid with d_ack
mem_address  out  32  word index = granted byte address >> 2, upper bits zero
mem_datain  out  32  formatted store data
mem_wen  out  1  memory write enable
mem_ren  out  1  memory read enable
mem_byte_selector  out  4  bit k enables bits [8k+7:8k]
mem_dataout  in  32  memory read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, last-grant pointer=D, all outputs 0 immediately; in-flight access dropped, no ack issued afterwards.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; all outputs registered.
- IDLE: at edge with any req high, grant and latch requester id, addr, we, size, unsigned, wdata; move to ISSUE. Requests are not sampled in ISSUE/WAIT/RESP.
- Arbitration: one requester -> grant it. Both -> grant the one not granted last; pointer updates on every grant. First conflict after reset goes to I.
- ISSUE (one cycle): mem_ren=1 (load/fetch) or mem_wen=1 (store), never both; mem_address, mem_byte_selector, mem_datain valid. Error transactions keep ren/wen=0.
- WAIT (one cycle): ren/wen=0; mem_dataout valid, formatted into rdata.
- RESP (one cycle): granted port's ack=1 with rdata/err; other port's ack=0. Next state IDLE. Issue rate: one access per 4 cycles; ack is visible 3 cycles after the sampling edge.
- I port: always word read, byte_selector=1111.
- Byte lanes (offset = addr[1:0]): byte -> bit offset; half -> 0011 (offset 0) or 1100 (offset 2); word -> 1111.
- Store data: byte -> wdata[7:0] replicated x4; half -> wdata[15:0] replicated x2; word -> as is.
- Load data: select the addressed byte/half lane, extend to 32 bits per d_unsigned; word passes through unchanged.
- Errors (err=1, rdata=0, no memory access, same 4-cycle timing):
  - d_size=11;
  - half with addr[0]=1;
  - word (I or D) with addr[1:0]!=0;
  - addr>>2 >= DEPTH.
- rdata/err hold their last value after ack; only ack is a pulse. Store ack has rdata=0.
- Requester dropping req before ack: the latched transaction still completes and acks.

Test Plan:
- Reset, then i_req=1 at i_addr=0x8 with mem word 2=0x12345678 -> mem_ren=1, mem_address=2, sel=1111 in cycle 2; i_ack=1, i_rdata=0x12345678 in cycle 4.
- D store byte 0xAB at 0x13 -> mem_wen=1, mem_address=4, sel=1000, mem_datain=0xABABABAB; d_ack=1, d_err=0.
- D load half at 0x12, mem word=0x8001_7F00: signed -> d_rdata=0xFFFF8001; unsigned -> 0x00008001. Load byte at 0x11 signed -> 0x0000007F.
- i_req and d_req both held continuously -> grants alternate I, D, I, D, each ack 4 cycles apart; no double-ack.
- Errors: word load at 0x2, half at 0x1, d_size=11, and byte address 0x1000 (index 1024) -> d_err=1, d_rdata=0, mem_ren/mem_wen never asserted.
- rst_n asserted low during WAIT of a store -> outputs 0 immediately, no ack after release; a new request then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port word memory between the fetch (I)
// and load/store (D) requesters, with byte-lane formatting and load extension.
module mem_arbiter #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_datain,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [3:0]  mem_byte_selector,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic        last_d;
  logic        gnt_d, t_we, t_uns, t_err;
  logic [1:0]  t_size, t_off;

  logic        req_any, grant_d, sel_we, err_c;
  logic [31:0] sel_addr, wdata_c, load_c;
  logic [1:0]  sel_size;
  logic [3:0]  lanes_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Grant decision and request formatting, evaluated only while IDLE
  always_comb begin
    state_next = state;
    req_any    = i_req | d_req;
    grant_d    = d_req & (~i_req | ~last_d);
    sel_addr   = grant_d ? d_addr : i_addr;
    sel_size   = grant_d ? d_size : 2'b10;
    sel_we     = grant_d & d_we;
    err_c      = ({2'b00, sel_addr[31:2]} >= DEPTH);
    lanes_c    = 4'b1111;
    wdata_c    = d_wdata;
    case (sel_size)
      2'b00: begin
        lanes_c = 4'b0001 << sel_addr[1:0];
        wdata_c = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        lanes_c = sel_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{d_wdata[15:0]}};
        if (sel_addr[0]) err_c = 1'b1;
      end
      2'b10: begin
        if (sel_addr[1:0] != 2'b00) err_c = 1'b1;
      end
      default: err_c = 1'b1;
    endcase

    case (state)
      IDLE:    if (req_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    byte_v = mem_dataout[{t_off, 3'b000} +: 8];
    half_v = t_off[1] ? mem_dataout[31:16] : mem_dataout[15:0];
    case (t_size)
      2'b00:   load_c = t_uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_c = t_uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_c = mem_dataout;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Transaction latch, memory strobes and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d            <= 1'b1;
      gnt_d             <= 1'b0;
      t_we              <= 1'b0;
      t_uns             <= 1'b0;
      t_err             <= 1'b0;
      t_size            <= 2'b00;
      t_off             <= 2'b00;
      i_ack             <= 1'b0;
      i_rdata           <= '0;
      i_err             <= 1'b0;
      d_ack             <= 1'b0;
      d_rdata           <= '0;
      d_err             <= 1'b0;
      mem_address       <= '0;
      mem_datain        <= '0;
      mem_wen           <= 1'b0;
      mem_ren           <= 1'b0;
      mem_byte_selector <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            gnt_d             <= grant_d;
            last_d            <= grant_d;
            t_we              <= sel_we;
            t_uns             <= d_unsigned;
            t_err             <= err_c;
            t_size            <= sel_size;
            t_off             <= sel_addr[1:0];
            mem_address       <= {2'b00, sel_addr[31:2]};
            mem_byte_selector <= lanes_c;
            mem_datain        <= sel_we ? wdata_c : 32'b0;
            mem_ren           <= ~err_c & ~sel_we;
            mem_wen           <= ~err_c & sel_we;
          end
        end
        WAIT: begin
          if (gnt_d) begin
            d_ack   <= 1'b1;
            d_err   <= t_err;
            d_rdata <= (t_err | t_we) ? 32'b0 : load_c;
          end else begin
            i_ack   <= 1'b1;
            i_err   <= t_err;
            i_rdata <= t_err ? 32'b0 : mem_dataout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses and memory
// accesses; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_unsigned = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_datain;
  logic        mem_wen;
  logic        mem_ren;
  logic [3:0]  mem_byte_selector;
  logic [31:0] mem_dataout = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } acc_t;

  resp_t i_q[$];
  resp_t d_q[$];
  acc_t  m_q[$];

  int checks = 0;
  int failures = 0;
  int acc_count = 0;
  logic [31:0] mem_model [0:1023];

  mem_arbiter #(.DEPTH(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_byte_selector(mem_byte_selector), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  initial begin
    for (int w = 0; w < 1024; w++) mem_model[w] = 32'h0;
    mem_model[2] = 32'h12345678;
    mem_model[4] = 32'h80017F00;
  end

  // Behavioural single-port memory: one-edge read latency, byte-masked writes
  always @(posedge clk) begin
    if (mem_wen && mem_address < 32'd1024)
      for (int k = 0; k < 4; k++)
        if (mem_byte_selector[k])
          mem_model[mem_address[9:0]][8*k +: 8] = mem_datain[8*k +: 8];
    if (mem_ren && mem_address < 32'd1024)
      mem_dataout <= mem_model[mem_address[9:0]];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  // Monitor: every ack and every memory strobe must match the next queued expectation
  always @(negedge clk) begin
    resp_t r;
    acc_t  a;
    if (rst_n) begin
      if (i_ack) begin
        if (i_q.size() == 0) failNow("i_unexpected_ack");
        else begin
          r = i_q.pop_front();
          checkOutput("i_rdata", i_rdata, r.rdata);
          checkOutput("i_err", i_err, r.err);
        end
      end
      if (d_ack) begin
        if (d_q.size() == 0) failNow("d_unexpected_ack");
        else begin
          r = d_q.pop_front();
          checkOutput("d_rdata", d_rdata, r.rdata);
          checkOutput("d_err", d_err, r.err);
        end
      end
      if (mem_ren || mem_wen) begin
        acc_count++;
        if (m_q.size() == 0) failNow("mem_unexpected_access");
        else begin
          a = m_q.pop_front();
          checkOutput("mem_wen_ren", {mem_wen, mem_ren}, {a.wen, ~a.wen});
          checkOutput("mem_address", mem_address, a.addr);
          checkOutput("mem_sel", mem_byte_selector, a.sel);
          if (a.wen) checkOutput("mem_datain", mem_datain, a.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic use_d, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err, input logic exp_mem,
                               input logic [31:0] exp_maddr, input logic [3:0] exp_sel,
                               input logic [31:0] exp_mdata);
    resp_t r;
    acc_t  a;
    int    waited;
    logic  got;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    if (use_d) d_q.push_back(r);
    else       i_q.push_back(r);
    if (exp_mem) begin
      a.wen  = we;
      a.addr = exp_maddr;
      a.sel  = exp_sel;
      a.data = exp_mdata;
      m_q.push_back(a);
    end
    @(negedge clk);
    if (use_d) begin
      d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns;
      d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    waited = 0;
    got = 1'b0;
    while (!got && waited < 10) begin
      @(negedge clk);
      waited++;
      if (use_d ? d_ack : i_ack) got = 1'b1;
    end
    if (!got) failNow("ack_timeout");
    else checkOutput("ack_latency", waited, 3);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  initial begin
    int   base;
    int   waited;
    int   ack_seen;
    logic got;
    acc_t a;
    resp_t r;

    #1 ;
    checkOutput("reset_i", {i_ack, i_err, i_rdata}, 64'h0);
    checkOutput("reset_d", {d_ack, d_err, d_rdata}, 64'h0);
    checkOutput("reset_mem", {mem_wen, mem_ren, mem_byte_selector, mem_address}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fetch, loads with extension, then stores and read-back
    applyStimulus(0, 0, 2'b10, 0, 32'h8,  0, 32'h12345678, 0, 1, 32'd2, 4'b1111, 0);
    applyStimulus(1, 0, 2'b01, 0, 32'h12, 0, 32'hFFFF8001, 0, 1, 32'd4, 4'b1100, 0);
    applyStimulus(1, 0, 2'b01, 1, 32'h12, 0, 32'h00008001, 0, 1, 32'd4, 4'b1100, 0);
    applyStimulus(1, 0, 2'b00, 0, 32'h11, 0, 32'h0000007F, 0, 1, 32'd4, 4'b0010, 0);
    applyStimulus(1, 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFF80, 0, 1, 32'd4, 4'b1000, 0);
    applyStimulus(1, 1, 2'b00, 0, 32'h13, 32'h123456AB, 32'h0, 0, 1, 32'd4, 4'b1000, 32'hABABABAB);
    applyStimulus(1, 0, 2'b00, 0, 32'h13, 0, 32'hFFFFFFAB, 0, 1, 32'd4, 4'b1000, 0);
    applyStimulus(1, 1, 2'b01, 0, 32'h16, 32'h1234CDEF, 32'h0, 0, 1, 32'd5, 4'b1100, 32'hCDEFCDEF);
    applyStimulus(1, 0, 2'b10, 0, 32'h14, 0, 32'hCDEF0000, 0, 1, 32'd5, 4'b1111, 0);
    applyStimulus(1, 1, 2'b10, 0, 32'h18, 32'hDEADBEEF, 32'h0, 0, 1, 32'd6, 4'b1111, 32'hDEADBEEF);
    applyStimulus(1, 0, 2'b10, 0, 32'h18, 0, 32'hDEADBEEF, 0, 1, 32'd6, 4'b1111, 0);
    applyStimulus(1, 0, 2'b01, 1, 32'h10, 0, 32'h00007F00, 0, 1, 32'd4, 4'b0011, 0);

    // Error cases: no memory strobe may appear
    base = acc_count;
    applyStimulus(1, 0, 2'b10, 0, 32'h2,    0, 32'h0, 1, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("d_err_hold", {d_ack, d_err, d_rdata}, {1'b0, 1'b1, 32'h0});
    applyStimulus(1, 0, 2'b01, 0, 32'h1,    0, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus(1, 0, 2'b11, 0, 32'h0,    0, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 2'b00, 0, 32'h1000, 32'h55, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 2'b10, 0, 32'h6,    0, 32'h0, 1, 0, 0, 0, 0);
    checkOutput("err_no_access", acc_count - base, 0);

    // Reset in the WAIT cycle of a store drops it silently
    a.wen = 1'b1; a.addr = 32'd7; a.sel = 4'b1111; a.data = 32'h11111111;
    m_q.push_back(a);
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h1C; d_wdata = 32'h11111111;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    d_req = 1'b0;
    #1 ;
    checkOutput("rst_mid_i", {i_ack, i_err, i_rdata}, 64'h0);
    checkOutput("rst_mid_d", {d_ack, d_err, d_rdata}, 64'h0);
    checkOutput("rst_mid_mem", {mem_wen, mem_ren, mem_byte_selector, mem_address}, 64'h0);
    checkOutput("rst_mid_datain", mem_datain, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ack_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d_ack || i_ack) ack_seen++;
    end
    checkOutput("no_ack_after_reset", ack_seen, 0);
    applyStimulus(1, 0, 2'b10, 0, 32'h18, 0, 32'hDEADBEEF, 0, 1, 32'd6, 4'b1111, 0);

    // Continuous contention after a D grant: I, D, I, D spaced four cycles apart
    for (int k = 0; k < 2; k++) begin
      a.wen = 1'b0; a.addr = 32'd2; a.sel = 4'b1111; a.data = 32'h0;
      m_q.push_back(a);
      a.addr = 32'd6;
      m_q.push_back(a);
      r.err = 1'b0;
      r.rdata = 32'h12345678; i_q.push_back(r);
      r.rdata = 32'hDEADBEEF; d_q.push_back(r);
    end
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h8;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h18;
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      got = 1'b0;
      while (!got && waited < 8) begin
        @(negedge clk);
        waited++;
        if (i_ack || d_ack) got = 1'b1;
      end
      if (!got) failNow("contention_timeout");
      else begin
        checkOutput("arb_order", {i_ack, d_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
        checkOutput("ack_gap", waited, (k == 0) ? 3 : 4);
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    repeat (8) @(negedge clk);

    checkOutput("i_q_empty", i_q.size(), 0);
    checkOutput("d_q_empty", d_q.size(), 0);
    checkOutput("m_q_empty", m_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout at %0t", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
